note_spawner: RTL
=================

NOTE_SPAWNER -- requirements
Module: note_spawner

Interface
- REQ-001 SHALL have parameter BEAT_CYCLES, default 1000: clock cycles per beat; legal range 8..65535.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 4: note queue entries; fixed at 4 for this revision.
- REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL have port enable, input, 1: runs note generation when high.
- REQ-006 SHALL have port random_bit, input, 1: serial pseudo-random bit from the LFSR stage, one new bit per clk.
- REQ-007 SHALL have port note_valid, output, 1: queue head holds a note.
- REQ-008 SHALL have port note_ready, input, 1: consumer accepts the head note.
- REQ-009 SHALL have port note_lane, output, 2: lane of the head note.
- REQ-010 SHALL have port note_type, output, 2: type of the head note.
- REQ-011 SHALL have port overflow, output, 1: sticky flag, set when a note was dropped.
- REQ-012 SHALL have port note_count, output, 8: count of notes accepted into the queue.

Function
- REQ-013 SHALL implement an FSM with states IDLE, COLLECT and WAIT_BEAT.
  - IDLE -> COLLECT when enable=1.
  - Any state -> IDLE on the next edge when enable=0.
- REQ-014 SHALL keep a 4-bit accumulator acc and a 2-bit bit counter.
  - Each COLLECT cycle: acc <= {acc[2:0], random_bit}; bit counter increments.
  - After the 4th sample (bit counter = 3): go to WAIT_BEAT with acc held.
- REQ-015 SHALL keep a 16-bit beat counter.
  - 0 in IDLE; increments every non-IDLE cycle.
  - Wraps to 0 after BEAT_CYCLES-1.
  - A beat tick is a cycle in which the counter = BEAT_CYCLES-1.
- REQ-016 SHALL, on a beat tick in WAIT_BEAT:
  - Form the note type=acc[3:2], lane=acc[1:0].
  - If type = 2'b00: treat as a rest, push nothing.
  - Otherwise: push the note.
  - Either way: return to COLLECT with the bit counter at 0.
- REQ-017 SHALL, on a beat tick in COLLECT (reachable only after reset of the counter alignment), push nothing and stay in COLLECT.
- REQ-018 SHALL implement a 4-entry FIFO.
  - note_valid = not empty.
  - note_lane and note_type = head entry; both 0 when empty.
- REQ-019 SHALL pop the head when note_valid=1 and note_ready=1.
- REQ-020 SHALL write a pushed note at the end of the push cycle; note_valid SHALL rise the following cycle if the FIFO was empty.
- REQ-021 SHALL, on a push when full:
  - Without a same-cycle pop: drop the note and set overflow.
  - With a same-cycle pop: accept the note; occupancy stays 4.
- REQ-022 SHALL increment note_count modulo 256 on every accepted push; dropped notes and rests do not count.
- REQ-023 SHALL, when enable falls mid-word, discard the partial word and clear acc, the bit counter and the beat counter.
  - The FIFO is retained and continues to drain.
  - overflow and note_count are retained.
- REQ-024 SHALL clear overflow only by reset.

Reset
- REQ-025 SHALL, while rst_n=0, asynchronously force:
  - state=IDLE; acc, bit counter, beat counter=0.
  - FIFO empty; note_valid=0, note_lane=0, note_type=0.
  - overflow=0, note_count=0.
- REQ-026 SHALL, on reset assertion mid-operation, discard all queued notes immediately; operation resumes on the first edge after rst_n=1 with enable=1.

Verification
- REQ-027 Basic note: BEAT_CYCLES=8, enable=1, random_bit 1,0,1,1 on the first four COLLECT cycles, note_ready=0 -> push on beat-counter cycle 7; next cycle note_valid=1, note_type=2'b10, note_lane=2'b11, note_count=1.
- REQ-028 Rest: stream 0,0,1,0 -> no push at the beat; note_valid stays 0; note_count unchanged.
- REQ-029 Overflow: note_ready=0; five consecutive non-rest words -> four entries held; overflow=1 after the 5th beat; note_count=4. Then note_ready=1 -> notes drain in push order; note_valid=0 after 4 pops.
- REQ-030 Full with simultaneous pop: FIFO full, note_ready=1 on a push beat -> new note accepted, overflow stays 0, occupancy 4.
- REQ-031 Enable drop: enable=0 after 2 COLLECT samples -> IDLE; queued notes still drain. Re-enable -> fresh 4-bit collection; first beat exactly BEAT_CYCLES cycles after entering COLLECT.
- REQ-032 Async reset: assert rst_n=0 between edges with 3 queued notes -> note_valid=0, note_count=0, overflow=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/note_spawner.sv
// Note spawner: gathers 4 random bits per beat into a note word and queues
// non-rest notes in a small FIFO for a downstream consumer.
module note_spawner #(
  parameter int unsigned BEAT_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       random_bit,
  output logic       note_valid,
  input  logic       note_ready,
  output logic [1:0] note_lane,
  output logic [1:0] note_type,
  output logic       overflow,
  output logic [7:0] note_count
);

  localparam int unsigned   PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0]   BEAT_LAST = 16'(BEAT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WAIT_BEAT = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  acc;
  logic [1:0]  bit_cnt;
  logic [15:0] beat_cnt;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   occ;
  logic [3:0]       head;

  logic beat_tick;
  logic push_req;
  logic fifo_pop;
  logic fifo_full;
  logic push_ok;

  always_comb begin
    beat_tick = (state != IDLE) && (beat_cnt == BEAT_LAST);
    // A falling enable wins over a pending beat: the word is abandoned.
    push_req  = enable && (state == WAIT_BEAT) && beat_tick && (acc[3:2] != 2'b00);
    fifo_pop  = note_valid && note_ready;
    fifo_full = (occ == OCC_FULL);
    push_ok   = push_req && (!fifo_full || fifo_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      bit_cnt  <= '0;
      beat_cnt <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      acc      <= '0;
      bit_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= COLLECT;
          beat_cnt <= '0;
        end
        COLLECT: begin
          acc      <= {acc[2:0], random_bit};
          bit_cnt  <= bit_cnt + 2'd1;
          beat_cnt <= beat_tick ? '0 : beat_cnt + 16'd1;
          if ((bit_cnt == 2'd3) && !beat_tick) begin
            state <= WAIT_BEAT;
          end
        end
        WAIT_BEAT: begin
          beat_cnt <= beat_tick ? '0 : beat_cnt + 16'd1;
          if (beat_tick) begin
            state   <= COLLECT;
            bit_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          acc      <= '0;
          bit_cnt  <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
      note_count <= '0;
    end else begin
      if (fifo_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        note_count <= note_count + 8'd1;
      end
      case ({push_ok, fifo_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    head       = mem[rd_ptr];
    note_valid = (occ != '0);
    note_type  = note_valid ? head[3:2] : 2'b00;
    note_lane  = note_valid ? head[1:0] : 2'b00;
  end

endmodule
